line_window_ctrl: RTL and testbench
===================================

Name: line_window_ctrl

Overview:
- Sequencer for the two-stage line-buffer chain (two cascaded syncLineFIFO shift lines, CE-gated, depth = one image line).
- Accepts a raster pixel stream and drives the chain's D/CE.
- Counts rows and columns, discards the fill period, and emits a registered 3-row vertical pixel column (rows n, n-1, n-2) with valid/ready handshake to the interpolation core.
- Detects framing errors and resynchronises on start-of-frame.

Parameters:
- DW, 8, pixel width in bits.
- IMG_W, 640, pixels per line; must equal line-FIFO depth.
- IMG_H, 480, lines per frame; minimum 3.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- s_data  in  DW  input pixel.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  controller can accept a pixel.
- s_user  in  1  start of frame; marks pixel row0/col0.
- s_last  in  1  end of line; marks col IMG_W-1.
- FIFO_D  out  DW  data to first line FIFO; combinational copy of s_data.
- FIFO_CE  out  1  shift enable for both line FIFOs.
- TAP1  in  DW  output of first line FIFO (row n-1).
- TAP2  in  DW  output of second line FIFO (row n-2).
- m_data  out  3*DW  window column: {TAP2, TAP1, s_data}, MSB = oldest row.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- m_user  out  1  first output column of a frame.
- m_last  out  1  last output column of a line.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- err  out  1  sticky framing error.
- clr_err  in  1  clears err.

Behaviour:
- Beat accepted ("acc") = s_valid & s_ready.
- States:
  - IDLE: s_ready=1. Beats without s_user are dropped (FIFO_CE=0). A beat with s_user is the row0/col0 pixel: FIFO_CE=1, col->1, go to FILL.
  - FILL: rows 0-1. s_ready=1, FIFO_CE=acc, no output. On acc of row1/col IMG_W-1, go to RUN.
  - RUN: rows 2..IMG_H-1. s_ready = !m_valid | m_ready; FIFO_CE=acc.
- Output register in RUN: on acc, load m_data={TAP2,TAP1,s_data} and set m_valid=1. m_user=1 iff row2/col0. m_last=1 iff col IMG_W-1.
- Output hold: m_valid clears on m_valid & m_ready without a new load. m_data/m_user/m_last are stable while m_valid & !m_ready. Latency is 1 cycle from acc to m_valid.
- Counters: col wraps IMG_W-1 -> 0 and increments row. On acc of row IMG_H-1/col IMG_W-1: go to IDLE, counters reset to 0, frame_done=1 on the next cycle only.
- s_last check, FILL/RUN only: s_last at col != IMG_W-1, or s_last=0 at col IMG_W-1, sets err=1 and goes to IDLE. The offending beat still shifts (FIFO_CE=1) but produces no output.
- SOF mid-frame: s_user on acc in FILL/RUN sets err=1. That beat is taken as row0/col0 of a new frame: col=1, row=0, state FILL. A pending m_valid is unaffected.
- err: set has priority over clr_err in the same cycle; otherwise clr_err clears it.
- Line FIFO contents are never cleared; FILL guarantees stale data never reaches m_data.
- Reset: state=IDLE, row=col=0, m_valid=0, m_data=0, m_user=0, m_last=0, frame_done=0, err=0. Reset mid-frame takes effect next cycle and any pending output is discarded.
- Width rule: counters are $clog2(IMG_W) and $clog2(IMG_H) bits, with no overflow beyond the terminal values.

Test Plan:
- Setup for all scenarios: IMG_W=4, IMG_H=4, DW=8.
- Nominal frame, m_ready=1: send pixels 0x00..0x0F with s_user on 0x00 and s_last on cols 3. Expect:
  - 8 FIFO_CE pulses with no m_valid during rows 0-1.
  - 8 outputs; the first is m_data={0x00,0x04,0x08} with m_user=1.
  - m_last on 0x0B and 0x0F.
  - frame_done one cycle after 0x0F.
- Backpressure: hold m_ready=0 for 3 cycles in RUN. Expect s_ready=0, FIFO_CE=0, m_data held; on release no pixel is lost or duplicated.
- Pre-SOF garbage: send 5 pixels without s_user in IDLE. Expect s_ready=1, FIFO_CE=0, no output; the following frame behaves as the nominal frame.
- Short line: s_last at col 2 of row 1. Expect err=1, state IDLE, no output until next SOF. clr_err then gives err=0.
- Mid-frame SOF: s_user at row2/col1. Expect err=1, row/col restart (row=0, col=1 after that beat); the next outputs appear only after 8 more accepted pixels.
- Reset during RUN with m_valid=1: expect m_valid=0 and state IDLE next cycle; the next full frame is correct.

Source files
------------

// File: rtl/line_window_ctrl.sv
// Sequencer for a two-line CE-gated line-buffer chain. It steps the chain with the
// raster input and emits a registered 3-row pixel column once two lines are buffered.
module line_window_ctrl #(
  parameter int DW    = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   s_data,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic            s_user,
  input  logic            s_last,
  output logic [DW-1:0]   FIFO_D,
  output logic            FIFO_CE,
  input  logic [DW-1:0]   TAP1,
  input  logic [DW-1:0]   TAP2,
  output logic [3*DW-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            m_user,
  output logic            m_last,
  output logic            frame_done,
  output logic            err,
  input  logic            clr_err,
  output logic [1:0]      dbg_state
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          acc, in_frame, col_end;
  logic          sof_err, last_err, beat_ok, frame_end, load;

  // Handshakes: a beat moves on a side when valid & ready are both high at a rising
  // edge; valid never waits on ready, and the output holds its payload until taken.
  assign acc       = s_valid & s_ready;
  assign in_frame  = (state != IDLE);
  assign col_end   = (col == COL_LAST);
  assign sof_err   = acc & in_frame & s_user;
  assign last_err  = acc & in_frame & ~s_user & (s_last != col_end);
  assign beat_ok   = acc & in_frame & ~s_user & (s_last == col_end);
  assign frame_end = beat_ok & (state == RUN) & col_end & (row == ROW_LAST);
  assign load      = beat_ok & (state == RUN);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc & s_user) state_nxt = FILL;
      FILL: begin
        if (sof_err)                                   state_nxt = FILL;
        else if (last_err)                             state_nxt = IDLE;
        else if (beat_ok & col_end & (row == RW'(1)))  state_nxt = RUN;
      end
      RUN: begin
        if (sof_err)                   state_nxt = FILL;
        else if (last_err | frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = 1'b1;
    FIFO_CE   = acc;
    FIFO_D    = s_data;
    dbg_state = state;
    case (state)
      IDLE:    FIFO_CE = acc & s_user;
      RUN:     s_ready = ~m_valid | m_ready;
      default: ;
    endcase
  end

  // A start-of-frame beat is pixel row0/col0 itself, so the next expected column is 1.
  always_ff @(posedge CLK) begin
    if (RST) begin
      col <= '0;
      row <= '0;
    end else if (acc & s_user) begin
      col <= CW'(1);
      row <= '0;
    end else if (last_err | frame_end) begin
      col <= '0;
      row <= '0;
    end else if (beat_ok) begin
      if (col_end) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_user  <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= {TAP2, TAP1, s_data};
      m_valid <= 1'b1;
      m_user  <= (row == RW'(2)) & (col == '0);
      m_last  <= col_end;
    end else if (m_valid & m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (sof_err | last_err) err <= 1'b1;
      else if (clr_err)       err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window_ctrl.sv
// Bench for line_window_ctrl: models the two line FIFOs and checks every cycle against
// a frame-position scoreboard, plus table-driven and hand-written corner sequences.
module tb_line_window_ctrl;
  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DW-1:0]   s_data = '0;
  logic            s_valid = 1'b0, s_user = 1'b0, s_last = 1'b0;
  logic            s_ready;
  logic [DW-1:0]   FIFO_D, TAP1, TAP2;
  logic            FIFO_CE;
  logic [3*DW-1:0] m_data;
  logic            m_valid, m_user, m_last, frame_done, err;
  logic            m_ready = 1'b1;
  logic            clr_err = 1'b0;
  logic [1:0]      dbg_state;

  line_window_ctrl #(.DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .CLK(CLK), .RST(RST), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_user(s_user), .s_last(s_last), .FIFO_D(FIFO_D), .FIFO_CE(FIFO_CE),
    .TAP1(TAP1), .TAP2(TAP2), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_user(m_user), .m_last(m_last), .frame_done(frame_done), .err(err),
    .clr_err(clr_err), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Two cascaded line FIFOs of depth W, shifted only on FIFO_CE.
  logic [DW-1:0] l1[W];
  logic [DW-1:0] l2[W];
  assign TAP1 = l1[W-1];
  assign TAP2 = l2[W-1];
  always @(posedge CLK) begin
    if (FIFO_CE) begin
      l1[0] <= FIFO_D;
      l2[0] <= l1[W-1];
      for (int i = 1; i < W; i++) begin
        l1[i] <= l1[i-1];
        l2[i] <= l2[i-1];
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: frame position counted as a flat pixel index; taps come from pixel history.
  logic [3*DW+1:0] exp_q[$];
  logic [DW-1:0]   hist[$];
  bit   sb_on = 0;
  bit   in_frame = 0;
  int   pos = 0;
  logic err_exp = 1'b0;
  logic fd_exp = 1'b0;

  always @(negedge CLK) begin : sb
    logic run, exp_sready, acc, ev_err, ev_end;
    if (sb_on) begin
      run        = in_frame && (pos >= 2*W);
      exp_sready = !run || (exp_q.size() == 0) || m_ready;
      chk("sb_m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
      if (m_valid && exp_q.size() != 0)
        chk("sb_m_out", 64'({m_user, m_last, m_data}), 64'(exp_q[0]));
      chk("sb_s_ready", 64'(s_ready), 64'(exp_sready));
      chk("sb_err", 64'(err), 64'(err_exp));
      chk("sb_frame_done", 64'(frame_done), 64'(fd_exp));
      acc = s_valid && exp_sready;
      chk("sb_fifo_ce", 64'(FIFO_CE), 64'(acc && (in_frame || s_user)));
      ev_err = 1'b0;
      ev_end = 1'b0;
      if (RST) begin
        exp_q.delete();
        in_frame = 0;
        pos = 0;
        err_exp = 1'b0;
        fd_exp = 1'b0;
      end else begin
        if (m_valid && m_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc && !in_frame && s_user) begin
          in_frame = 1;
          pos = 1;
          hist.push_back(s_data);
        end else if (acc && in_frame) begin
          if (s_user) begin
            ev_err = 1'b1;
            pos = 1;
          end else if (s_last != ((pos % W) == W-1)) begin
            ev_err = 1'b1;
            in_frame = 0;
            pos = 0;
          end else begin
            if (pos >= 2*W)
              exp_q.push_back({pos == 2*W, (pos % W) == W-1, hist[0], hist[W], s_data});
            pos++;
            if (pos == W*H) begin
              in_frame = 0;
              pos = 0;
              ev_end = 1'b1;
            end
          end
          hist.push_back(s_data);
        end
        while (hist.size() > 2*W) void'(hist.pop_front());
        err_exp = ev_err ? 1'b1 : (clr_err ? 1'b0 : err_exp);
        fd_exp  = ev_end;
      end
    end
  end

  bit rand_m = 0;
  bit rand_gap = 0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l);
    int n = 0;
    s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
    if (rand_m) m_ready = ($urandom_range(0, 3) != 0);
    @(negedge CLK);
    while (!s_ready && n < 50) begin
      tick();
      if (rand_m) m_ready = ($urandom_range(0, 3) != 0);
      @(negedge CLK);
      n++;
    end
    if (!s_ready) chk("send_timeout", 64'(s_ready), 64'(1));
    tick();
    s_valid = 1'b0;
    if (rand_gap) repeat ($urandom_range(0, 2)) begin
      if (rand_m) m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  task automatic send_frame(input int base, input int first, input int n);
    for (int i = first; i < first + n; i++)
      send_beat(DW'(base + i), i == 0, (i % W) == W-1);
  endtask

  typedef struct {
    logic [DW-1:0]   d;
    logic            u, l, ev;
    logic [3*DW-1:0] ed;
    logic            eu, el, efd;
  } vec_t;
  vec_t tbl[W*H];

  task automatic run_table();
    m_ready = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      s_data = tbl[i].d; s_user = tbl[i].u; s_last = tbl[i].l; s_valid = 1'b1;
      @(negedge CLK);
      chk("tbl_s_ready", 64'(s_ready), 64'(1));
      chk("tbl_fifo_ce", 64'(FIFO_CE), 64'(1));
      tick();
      s_valid = 1'b0;
      chk("tbl_m_valid", 64'(m_valid), 64'(tbl[i].ev));
      if (tbl[i].ev)
        chk("tbl_m_out", 64'({m_user, m_last, m_data}), 64'({tbl[i].eu, tbl[i].el, tbl[i].ed}));
      chk("tbl_frame_done", 64'(frame_done), 64'(tbl[i].efd));
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) begin
      tbl[i].d   = DW'(i);
      tbl[i].u   = (i == 0);
      tbl[i].l   = (i % W) == W-1;
      tbl[i].ev  = (i >= 2*W);
      tbl[i].ed  = {DW'(i - 2*W), DW'(i - W), DW'(i)};
      tbl[i].eu  = (i == 2*W);
      tbl[i].el  = (i >= 2*W) && ((i % W) == W-1);
      tbl[i].efd = (i == W*H - 1);
    end

    RST = 1'b1;
    tick(); tick();
    sb_on = 1;
    tick();
    RST = 1'b0;
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_user_last", 64'({m_user, m_last}), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    tick();

    run_table();

    // Garbage before start-of-frame is dropped.
    for (int i = 0; i < 5; i++) begin
      s_data = DW'($urandom_range(0, 255)); s_user = 1'b0; s_last = 1'b0; s_valid = 1'b1;
      @(negedge CLK);
      chk("pre_sof_s_ready", 64'(s_ready), 64'(1));
      chk("pre_sof_fifo_ce", 64'(FIFO_CE), 64'(0));
      tick();
      s_valid = 1'b0;
      chk("pre_sof_m_valid", 64'(m_valid), 64'(0));
    end
    run_table();

    // Backpressure in RUN: hold m_ready low for three cycles with a beat waiting.
    send_frame(32'h20, 0, 2*W + 2);
    m_ready = 1'b0;
    s_data = 8'h2A; s_user = 1'b0; s_last = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_s_ready", 64'(s_ready), 64'(0));
      chk("bp_fifo_ce", 64'(FIFO_CE), 64'(0));
      chk("bp_m_data", 64'({m_valid, m_data}), 64'({1'b1, 8'h21, 8'h25, 8'h29}));
      tick();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    send_frame(32'h20, 2*W + 2, W*H - 2*W - 2);
    tick();

    // Short line: s_last at row 1 / col 2.
    send_frame(32'h40, 0, W + 2);
    send_beat(8'h46, 1'b0, 1'b1);
    chk("short_err", 64'(err), 64'(1));
    chk("short_state", 64'(dbg_state), 64'(0));
    for (int i = 0; i < 3; i++) begin
      send_beat(DW'(8'h47 + i), 1'b0, (i == 0));
      chk("short_no_out", 64'(m_valid), 64'(0));
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("short_clr_err", 64'(err), 64'(0));

    // Start-of-frame arriving at row 2 / col 1.
    send_frame(32'h50, 0, 2*W + 1);
    send_beat(8'h60, 1'b1, 1'b0);
    chk("msof_err", 64'(err), 64'(1));
    chk("msof_state", 64'(dbg_state), 64'(1));
    for (int i = 1; i < 2*W; i++) begin
      send_beat(DW'(8'h60 + i), 1'b0, (i % W) == W-1);
      chk("msof_no_out", 64'(m_valid), 64'(0));
    end
    send_beat(DW'(8'h60 + 2*W), 1'b0, 1'b0);
    chk("msof_first_out", 64'({m_valid, m_user, m_data}), 64'({2'b11, 8'h60, 8'h64, 8'h68}));
    send_frame(32'h60, 2*W + 1, W*H - 2*W - 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Reset while an output is pending.
    send_frame(32'h70, 0, 2*W + 1);
    m_ready = 1'b0;
    chk("rstrun_pending", 64'(m_valid), 64'(1));
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rstrun_m_valid", 64'(m_valid), 64'(0));
    chk("rstrun_state", 64'(dbg_state), 64'(0));
    m_ready = 1'b1;
    send_frame(32'h80, 0, W*H);
    tick();

    // Randomized frames with random backpressure, gaps and occasional framing faults.
    rand_m = 1;
    rand_gap = 1;
    for (int f = 0; f < 12; f++) begin
      int base;
      base = $urandom_range(0, 255);
      repeat ($urandom_range(0, 3)) send_beat(DW'($urandom_range(0, 255)), 1'b0, 1'b0);
      for (int i = 0; i < W*H; i++) begin
        logic u, l;
        u = (i == 0) || ($urandom_range(0, 59) == 0);
        l = ((i % W) == W-1) ^ ($urandom_range(0, 49) == 0);
        send_beat(DW'(base + i), u, l);
      end
      clr_err = ($urandom_range(0, 1) != 0);
      tick();
      clr_err = 1'b0;
    end
    rand_m = 0;
    rand_gap = 0;
    m_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
